// File: rtl/dla_pkg.sv
// Shared types and default widths for the DLA datapath blocks.
// The MAC accumulator and its requantiser both import this package.
package dla_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } mac_state_e;

    localparam int DLA_IN_WIDTH  = 8;
    localparam int DLA_ACC_WIDTH = 24;
    localparam int DLA_OUT_WIDTH = 8;
    localparam int DLA_VEC_LEN   = 16;
    localparam int DLA_SHIFT     = 4;

    // Smallest accumulator that cannot overflow over a whole vector of worst-case products.
    function automatic int min_acc_width(input int in_width, input int vec_len);
        return 2 * in_width + $clog2(vec_len);
    endfunction

endpackage : dla_pkg

// File: rtl/requant_sat.sv
// Combinational requantiser: round-half-up arithmetic right shift of the
// accumulator, then signed saturation to OUT_WIDTH with a clip flag.
module requant_sat #(
    parameter int ACC_WIDTH = dla_pkg::DLA_ACC_WIDTH,
    parameter int OUT_WIDTH = dla_pkg::DLA_OUT_WIDTH,
    parameter int SHIFT     = dla_pkg::DLA_SHIFT
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic signed [OUT_WIDTH-1:0] out_o,
    output logic                        sat_o
);

    // One guard bit so the rounding increment can never wrap.
    localparam int EW = ACC_WIDTH + 1;

    localparam logic signed [EW-1:0] OUT_MAX =
        {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] OUT_MIN =
        {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [EW-1:0] acc_ext;
    logic signed [EW-1:0] shifted;

    assign acc_ext = {acc_i[ACC_WIDTH-1], acc_i};

    if (SHIFT > 0) begin : g_round
        localparam logic signed [EW-1:0] HALF = {{(EW-1){1'b0}}, 1'b1} << (SHIFT - 1);
        logic signed [EW-1:0] rounded;
        assign rounded = acc_ext + HALF;
        assign shifted = rounded >>> SHIFT;
    end else begin : g_pass
        assign shifted = acc_ext;
    end

    always_comb begin
        out_o = shifted[OUT_WIDTH-1:0];
        sat_o = 1'b0;
        if (shifted > OUT_MAX) begin
            out_o = OUT_MAX[OUT_WIDTH-1:0];
            sat_o = 1'b1;
        end else if (shifted < OUT_MIN) begin
            out_o = OUT_MIN[OUT_WIDTH-1:0];
            sat_o = 1'b1;
        end
    end

endmodule : requant_sat

// File: rtl/mac_accumulator.sv
// Vector MAC: accumulates VEC_LEN signed a*w products, then presents one
// requantised, saturated result and holds it until the consumer takes it.
module mac_accumulator
    import dla_pkg::*;
#(
    parameter int IN_WIDTH  = DLA_IN_WIDTH,
    parameter int ACC_WIDTH = DLA_ACC_WIDTH,
    parameter int OUT_WIDTH = DLA_OUT_WIDTH,
    parameter int VEC_LEN   = DLA_VEC_LEN,
    parameter int SHIFT     = DLA_SHIFT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  w,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        out_sat
);

    localparam int PW = 2 * IN_WIDTH;
    localparam int CW = $clog2(VEC_LEN + 1);

    if (ACC_WIDTH < min_acc_width(IN_WIDTH, VEC_LEN)) begin : g_bad_acc_width
        $error("mac_accumulator: ACC_WIDTH too small for IN_WIDTH and VEC_LEN");
    end
    if (VEC_LEN < 2 || VEC_LEN > 256) begin : g_bad_vec_len
        $error("mac_accumulator: VEC_LEN outside 2..256");
    end
    if (SHIFT < 0 || SHIFT > ACC_WIDTH - 1) begin : g_bad_shift
        $error("mac_accumulator: SHIFT outside 0..ACC_WIDTH-1");
    end

    mac_state_e                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]               count_q, count_d;
    logic signed [OUT_WIDTH-1:0] out_q, out_d;
    logic                        out_sat_q, out_sat_d;

    logic signed [PW-1:0]        a_ext, w_ext, prod;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [OUT_WIDTH-1:0] rq_out;
    logic                        rq_sat;
    logic                        last_beat;

    // Sign-extend before multiplying so the full 2*IN_WIDTH product is kept.
    assign a_ext   = {{IN_WIDTH{a[IN_WIDTH-1]}}, a};
    assign w_ext   = {{IN_WIDTH{w[IN_WIDTH-1]}}, w};
    assign prod    = a_ext * w_ext;
    assign acc_sum = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

    assign last_beat = (count_q == CW'(VEC_LEN - 1));

    // Requantise the sum including the final beat so the result lands with the DRAIN entry.
    requant_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_requant_sat (
        .acc_i (acc_sum),
        .out_o (rq_out),
        .sat_o (rq_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            count_q   <= '0;
            out_q     <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            out_q     <= out_d;
            out_sat_q <= out_sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        out_d     = out_q;
        out_sat_d = out_sat_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = acc_sum;
                    count_d = count_q + CW'(1);
                    if (last_beat) begin
                        state_d   = DRAIN;
                        out_d     = rq_out;
                        out_sat_d = rq_sat;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign out     = out_q;
    assign out_sat = out_sat_q;

endmodule : mac_accumulator

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator (default parameters) with a result scoreboard.
module tb_mac_accumulator;

    localparam int IW = 8;
    localparam int OW = 8;
    localparam int VL = 16;
    localparam int SH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IW-1:0] a;
    logic signed [IW-1:0] w;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out;
    logic                 out_sat;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        longint value;
        longint sat;
    } exp_t;
    exp_t sb_q[$];

    longint model_acc = 0;
    int     model_beats = 0;

    always #5 clk = ~clk;

    mac_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_sat   (out_sat)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference result: floor((acc + 2^(SH-1)) / 2^SH), then clip to OW bits.
    function automatic exp_t model_result(input longint acc);
        exp_t   e;
        longint r;
        longint hi = (64'sd1 <<< (OW - 1)) - 1;
        longint lo = -(64'sd1 <<< (OW - 1));
        r = (SH > 0) ? ((acc + (64'sd1 <<< (SH - 1))) >>> SH) : acc;
        e.sat = 0;
        if (r > hi) begin r = hi; e.sat = 1; end
        if (r < lo) begin r = lo; e.sat = 1; end
        e.value = r;
        return e;
    endfunction

    // Drives one beat starting at a negedge; returns at the next negedge.
    task automatic beat(input int av, input int wv);
        a = IW'(av);
        w = IW'(wv);
        in_valid = 1'b1;
        check("in_ready_accum", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        model_acc += longint'(av) * longint'(wv);
        model_beats++;
        if (model_beats == VL) begin
            sb_q.push_back(model_result(model_acc));
            $display("beat vector complete: acc=%0d queued out=%0d sat=%0d",
                     model_acc, model_result(model_acc).value, model_result(model_acc).sat);
            model_acc = 0;
            model_beats = 0;
        end
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rep(input int n, input int av, input int wv);
        for (int i = 0; i < n; i++) beat(av, wv);
    endtask

    // Called right after the last beat: result must already be valid.
    task automatic drain(input int hold);
        exp_t e;
        logic signed [OW-1:0] held;
        int waited = 0;
        check("out_valid_latency", out_valid, 1);
        while (out_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check("out_value", out, e.value);
        check("out_sat", out_sat, e.sat);
        $display("result: out=%0d sat=%0d expected out=%0d sat=%0d", out, out_sat, e.value, e.sat);
        held = out;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = IW'($urandom_range(255));
            w = IW'($urandom_range(255));
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_stable", out, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        w = '0;
        repeat (2) @(negedge clk);
        check("reset_out", out, 0);
        check("reset_out_sat", out_sat, 0);
        check("reset_out_valid", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);

        // Unity vector: acc=16 -> out=1
        rep(VL, 1, 1);
        drain(0);
        // Positive and negative saturation
        rep(VL, 127, 127);
        drain(0);
        rep(VL, -128, 127);
        drain(0);
        // Rounding boundary: acc=8 rounds up, acc=7 rounds down
        rep(8, 1, 1); rep(8, 0, 0);
        drain(0);
        rep(7, 1, 1); rep(9, 0, 0);
        drain(0);
        // Backpressure for 5 cycles with beats offered
        rep(VL, 3, 2);
        drain(5);

        // Reset mid-vector, asserted together with a beat
        rep(7, 5, 5);
        a = 8'sd5; w = 8'sd5; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        model_acc = 0;
        model_beats = 0;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        rep(VL, 2, 1);
        drain(0);

        // Mixed-sign vector, gap-free, then the same values with random gaps
        for (int i = 0; i < VL; i++) beat(i * 7 - 50, 13 - i * 3);
        drain(0);
        for (int i = 0; i < VL; i++) begin
            gap($urandom_range(3));
            beat(i * 7 - 50, 13 - i * 3);
        end
        drain(2);

        // Back-to-back vectors
        rep(VL, -3, 9);
        drain(0);
        rep(VL, 20, 20);
        drain(0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mac_accumulator

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: signed activation/weight width.
REQ-002 SHALL have parameter ACC_WIDTH, default 24: signed accumulator width.
REQ-003 SHALL have parameter OUT_WIDTH, default 8: signed result width; matches the downstream ReLU IN_WIDTH.
REQ-004 SHALL have parameter VEC_LEN, default 16: products summed per result, legal range 2..256.
REQ-005 SHALL have parameter SHIFT, default 4: requantisation right-shift, legal range 0..ACC_WIDTH-1.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: a/w beat is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-010 SHALL have port a, input, IN_WIDTH bits, signed: activation.
REQ-011 SHALL have port w, input, IN_WIDTH bits, signed: weight.
REQ-012 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer (ReLU stage) takes the result.
REQ-014 SHALL have port out, output, OUT_WIDTH bits, signed: requantised result.
REQ-015 SHALL have port out_sat, output, 1 bit: out was clipped; qualified by out_valid.

Function
REQ-016 SHALL implement two states. ACCUM: in_ready=1, out_valid=0. DRAIN: in_ready=0, out_valid=1.
REQ-017 SHALL accept a beat in ACCUM when in_valid=1: acc <= acc + sext(a*w); beat count increments.
REQ-018 SHALL go to DRAIN on the clock edge that accepts beat VEC_LEN; out/out_sat SHALL be valid on the following cycle (1-cycle latency from last beat).
REQ-019 SHALL, when SHIFT>0, compute out as (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. arithmetic shift with round-half-up; when SHIFT=0, out is acc unchanged.
REQ-020 SHALL saturate that value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and SHALL set out_sat=1 iff clipping occurred.
REQ-021 SHALL hold out, out_sat and out_valid stable in DRAIN while out_ready=0, with no beat accepted.
REQ-022 SHALL, in DRAIN with out_ready=1, return to ACCUM next cycle with acc=0 and count=0; no beat is accepted in that same cycle.
REQ-023 SHALL leave acc and count unchanged on ACCUM cycles with in_valid=0 (gaps allowed).
REQ-024 SHALL wrap the accumulator modulo 2^ACC_WIDTH; elaboration SHALL fail if ACC_WIDTH < 2*IN_WIDTH + clog2(VEC_LEN).
REQ-025 SHALL use a full-width signed product (2*IN_WIDTH bits) with no truncation before accumulation.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state=ACCUM, acc=0, count=0, out=0, out_sat=0, out_valid=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-027 SHALL give rst priority over any simultaneous beat or out_ready; a partial vector is discarded on reset mid-operation.

Structure
REQ-028 SHALL place the state enum (ACCUM, DRAIN) and default width constants in shared package dla_pkg.
REQ-029 SHALL implement rounding, shift and saturation in combinational sub-module requant_sat (ACC_WIDTH in, OUT_WIDTH plus sat flag out), registered in mac_accumulator.

Verification (defaults)
REQ-030 SHALL verify 16 beats of a=1, w=1 -> acc=16, out=1, out_sat=0, out_valid exactly one cycle after beat 16.
REQ-031 SHALL verify 16 beats of a=127, w=127 -> acc=258064, out=127, out_sat=1; 16 beats of a=-128, w=127 -> out=-128, out_sat=1.
REQ-032 SHALL verify rounding: 8 beats of (1,1) plus 8 beats of (0,0) -> out=1 (acc=8); 7 beats of (1,1) plus 9 beats of (0,0) -> out=0 (acc=7).
REQ-033 SHALL verify backpressure: out_ready=0 for 5 cycles in DRAIN -> out_valid=1, out stable, in_ready=0, in_valid beats ignored; then out_ready=1 -> in_ready=1 next cycle.
REQ-034 SHALL verify reset after 7 beats of (5,5) followed by 16 beats of (2,1) -> out=2 with no contribution from the pre-reset beats.
REQ-035 SHALL verify random in_valid gaps across 16 beats -> result equals the gap-free run; back-to-back vectors produce results one vector apart.
